fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: buffers {PC, instruction} pairs from fetch and presents
// the oldest to decode, with a one-cycle flush for branch/jump redirects.
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       inValid,
  input  logic [ADDR_WIDTH-1:0]      inPC,
  input  logic [INSTR_WIDTH-1:0]     inInstr,
  output logic                       inReady,
  output logic                       outValid,
  output logic [ADDR_WIDTH-1:0]      outPC,
  output logic [INSTR_WIDTH-1:0]     outInstr,
  input  logic                       outReady,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0]  pcMem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instrMem [DEPTH];

  logic [PtrW-1:0] wrPtrQ, wrPtrD;
  logic [PtrW-1:0] rdPtrQ, rdPtrD;
  logic [CntW-1:0] countQ, countD;

  logic push;
  logic pop;

  // Handshake status comes from registered state only, so there is no in-to-out path.
  assign inReady  = (countQ != CntW'(DEPTH));
  assign outValid = (countQ != '0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;
  assign count    = countQ;

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (push) begin
        wrPtrD = wrPtrQ + PtrW'(1);
      end
      if (pop) begin
        rdPtrD = rdPtrQ + PtrW'(1);
      end
      if (push && !pop) begin
        countD = countQ + CntW'(1);
      end else if (pop && !push) begin
        countD = countQ - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage is left uncleared on reset/flush; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pcMem[wrPtrQ]    <= inPC;
      instrMem[wrPtrQ] <= inInstr;
    end
  end

  always_comb begin
    outPC    = '0;
    outInstr = NOP_INSTR;
    if (outValid) begin
      outPC    = pcMem[rdPtrQ];
      outInstr = instrMem[rdPtrQ];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;
  localparam logic [IW-1:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic [AW-1:0] inPC = '0;
  logic [IW-1:0] inInstr = '0;
  logic          inReady;
  logic          outValid;
  logic [AW-1:0] outPC;
  logic [IW-1:0] outInstr;
  logic          outReady = 1'b0;
  logic [CW-1:0] count;

  int passCnt  = 0;
  int totalCnt = 0;

  // Model: entries held oldest-first as {pc, instr}.
  logic [AW+IW-1:0] model[$];

  fetch_queue #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .DEPTH      (D),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .inValid (inValid),
    .inPC    (inPC),
    .inInstr (inInstr),
    .inReady (inReady),
    .outValid(outValid),
    .outPC   (outPC),
    .outInstr(outInstr),
    .outReady(outReady),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the active edge, from the inputs held across it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model.delete();
    end else if (flush) begin
      model.delete();
    end else begin
      int sz;
      bit doPush, doPop;
      sz     = model.size();
      doPush = inValid && (sz < D);
      doPop  = outReady && (sz > 0);
      if (doPop) void'(model.pop_front());
      if (doPush) model.push_back({inPC, inInstr});
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      int sz;
      logic [AW-1:0] ePC;
      logic [IW-1:0] eIn;
      sz  = model.size();
      ePC = '0;
      eIn = NOP;
      if (sz > 0) begin
        ePC = model[0][AW+IW-1:IW];
        eIn = model[0][IW-1:0];
      end
      chk("count", 64'(count), 64'(sz));
      chk("inReady", 64'(inReady), 64'(sz != D));
      chk("outValid", 64'(outValid), 64'(sz != 0));
      chk("outPC", 64'(outPC), 64'(ePC));
      chk("outInstr", 64'(outInstr), 64'(eIn));
    end
  end

  // Hold inputs across one active edge, return at the following falling edge.
  task automatic cyc(input logic f, input logic v, input logic [AW-1:0] pc,
                     input logic [IW-1:0] ins, input logic r);
    flush    = f;
    inValid  = v;
    inPC     = pc;
    inInstr  = ins;
    outReady = r;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with inValid high: nothing captured.
    inValid = 1'b1;
    inPC    = 16'h1234;
    inInstr = 32'hDEADBEEF;
    #2;
    chk("rst count", 64'(count), 64'd0);
    chk("rst inReady", 64'(inReady), 64'd1);
    chk("rst outValid", 64'(outValid), 64'd0);
    chk("rst outInstr", 64'(outInstr), 64'h13);
    chk("rst outPC", 64'(outPC), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst hold count", 64'(count), 64'd0);
    inValid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);

    // Fill with decode stalled, then attempt a fifth push.
    for (int i = 0; i < 4; i++) cyc(0, 1, AW'(4 * i), IW'(32'hA0 + i), 0);
    chk("fill count", 64'(count), 64'd4);
    chk("fill inReady", 64'(inReady), 64'd0);
    cyc(0, 1, 16'h0010, 32'hA4, 0);
    chk("fifth count", 64'(count), 64'd4);
    chk("fifth head pc", 64'(outPC), 64'h0000);
    chk("fifth head instr", 64'(outInstr), 64'hA0);
    for (int i = 0; i < 4; i++) begin
      chk("drain pc", 64'(outPC), 64'(4 * i));
      chk("drain instr", 64'(outInstr), 64'(32'hA0 + i));
      cyc(0, 0, '0, '0, 1);
    end
    chk("drained outValid", 64'(outValid), 64'd0);
    chk("drained outInstr", 64'(outInstr), 64'h13);
    chk("drained outPC", 64'(outPC), 64'd0);

    // Streaming across pointer wraps with count held at 1.
    cyc(0, 1, 16'h0100, 32'hB000_0000, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, AW'(16'h0100 + 4 * i), IW'(32'hB000_0000 + i), 1);
      chk("stream count", 64'(count), 64'd1);
      chk("stream pc", 64'(outPC), 64'(16'h0100 + 4 * i));
    end
    cyc(0, 0, '0, '0, 1);
    chk("stream empty", 64'(count), 64'd0);

    // Flush wins over simultaneous push and pop.
    for (int i = 0; i < 3; i++) cyc(0, 1, AW'(16'h0300 + 4 * i), IW'(32'hC0 + i), 0);
    chk("pre-flush count", 64'(count), 64'd3);
    cyc(1, 1, 16'h0ABC, 32'hFFFF_FFFF, 1);
    chk("flush count", 64'(count), 64'd0);
    chk("flush outValid", 64'(outValid), 64'd0);
    chk("flush inReady", 64'(inReady), 64'd1);
    cyc(0, 1, 16'h0200, 32'hD0, 0);
    chk("post-flush count", 64'(count), 64'd1);
    chk("post-flush pc", 64'(outPC), 64'h0200);
    chk("post-flush instr", 64'(outInstr), 64'hD0);
    cyc(0, 0, '0, '0, 1);

    // Full with pop: pop happens, push refused, then next push accepted.
    for (int i = 0; i < 4; i++) cyc(0, 1, AW'(16'h0400 + 4 * i), IW'(32'hE0 + i), 0);
    cyc(0, 1, 16'h0410, 32'hE4, 1);
    chk("full-pop count", 64'(count), 64'd3);
    chk("full-pop inReady", 64'(inReady), 64'd1);
    chk("full-pop head", 64'(outPC), 64'h0404);
    cyc(0, 1, 16'h0414, 32'hE5, 0);
    chk("refill count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, 1);

    // Async reset between edges with two entries buffered.
    cyc(0, 1, 16'h0500, 32'hF0, 0);
    cyc(0, 1, 16'h0504, 32'hF1, 0);
    inValid = 1'b0;
    chk("pre-rst count", 64'(count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("async count", 64'(count), 64'd0);
    chk("async outValid", 64'(outValid), 64'd0);
    chk("async outInstr", 64'(outInstr), 64'h13);
    #1 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic, checked by the compare process every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, AW'($urandom),
          IW'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
